// File: rtl/mem_port_arbiter.sv
// Single-port SRAM arbiter between fetch (IF) and data (DM) stages, DM-priority with a fetch anti-starvation streak.
// Optional build macro ARB_PERF_CNT_EN adds conflict/force performance counters.
module mem_port_arbiter #(
   parameter int unsigned RD_LATENCY = 1,
   parameter int unsigned STREAK_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_rvalid,
   output logic        stallreq_if,
   input  logic        dm_req,
   input  logic [3:0]  dm_wen,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   output logic [31:0] dm_rdata,
   output logic        dm_rvalid,
   output logic        stallreq_dm,
   output logic        sram_en,
   output logic [3:0]  sram_wen,
   output logic [31:0] sram_addr,
   output logic [31:0] sram_wdata,
   input  logic [31:0] sram_rdata
`ifdef ARB_PERF_CNT_EN
   ,
   output logic [31:0] perf_conflict_cnt,
   output logic [31:0] perf_force_cnt
`endif
);

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } owner_t;

   logic [3:0]  streak;
   logic [3:0]  streak_nxt;
   logic        force_if;
   logic        grant_if;
   logic        grant_dm;
   logic        push_valid;
   owner_t      push_owner;
   logic        tag_valid [RD_LATENCY];
   owner_t      tag_owner [RD_LATENCY];
   logic        tail_if;
   logic        tail_dm;
   logic [31:0] if_rdata_q;
   logic [31:0] dm_rdata_q;

   // Grant and SRAM bus; everything is masked while reset is asserted so outputs read 0.
   always_comb begin
      force_if    = (streak == 4'(STREAK_MAX));
      grant_if    = rst & if_req & (~dm_req | force_if);
      grant_dm    = rst & dm_req & ~grant_if;
      stallreq_if = rst & if_req & ~grant_if;
      stallreq_dm = rst & dm_req & ~grant_dm;
      sram_en     = 1'b0;
      sram_wen    = '0;
      sram_addr   = '0;
      sram_wdata  = '0;
      if (grant_dm) begin
         sram_en    = 1'b1;
         sram_wen   = dm_wen;
         sram_addr  = dm_addr;
         sram_wdata = dm_wdata;
      end else if (grant_if) begin
         sram_en   = 1'b1;
         sram_addr = if_addr;
      end
   end

   always_comb begin
      streak_nxt = streak;
      if (!if_req || grant_if) begin
         streak_nxt = '0;
      end else if (grant_dm && !force_if) begin
         streak_nxt = streak + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         streak <= '0;
      end else begin
         streak <= streak_nxt;
      end
   end

   // A flushed IF grant enters the pipeline already invalid.
   always_comb begin
      push_valid = (grant_dm & (dm_wen == '0)) | (grant_if & ~flush);
      push_owner = grant_dm ? OWN_DM : OWN_IF;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int unsigned i = 0; i < RD_LATENCY; i++) begin
            tag_valid[i] <= 1'b0;
         end
      end else begin
         tag_valid[0] <= push_valid;
         for (int unsigned i = 1; i < RD_LATENCY; i++) begin
            tag_valid[i] <= tag_valid[i-1] & ~(flush & (tag_owner[i-1] == OWN_IF));
         end
      end
   end

   always_ff @(posedge clk) begin
      tag_owner[0] <= push_owner;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
         tag_owner[i] <= tag_owner[i-1];
      end
   end

   // The tail entry is visible in the cycle its data arrives; flush also drops an IF tail in that cycle.
   always_comb begin
      tail_if   = rst & ~flush & tag_valid[RD_LATENCY-1] & (tag_owner[RD_LATENCY-1] == OWN_IF);
      tail_dm   = rst & tag_valid[RD_LATENCY-1] & (tag_owner[RD_LATENCY-1] == OWN_DM);
      if_rvalid = tail_if;
      dm_rvalid = tail_dm;
      if_rdata  = '0;
      dm_rdata  = '0;
      if (rst) begin
         if_rdata = tail_if ? sram_rdata : if_rdata_q;
         dm_rdata = tail_dm ? sram_rdata : dm_rdata_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else begin
         if (tail_if) begin
            if_rdata_q <= sram_rdata;
         end
         if (tail_dm) begin
            dm_rdata_q <= sram_rdata;
         end
      end
   end

`ifdef ARB_PERF_CNT_EN
   logic [31:0] conflict_q;
   logic [31:0] force_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         conflict_q <= '0;
         force_q    <= '0;
      end else begin
         if (if_req && dm_req) begin
            conflict_q <= conflict_q + 32'd1;
         end
         if (force_if) begin
            force_q <= force_q + 32'd1;
         end
      end
   end

   always_comb begin
      perf_conflict_cnt = rst ? conflict_q : '0;
      perf_force_cnt    = rst ? force_q : '0;
   end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter with a behavioural SRAM and reference model.
module tb_mem_port_arbiter;
   localparam int L    = 2;
   localparam int SMAX = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flush = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic [31:0] if_rdata;
   logic        if_rvalid;
   logic        stallreq_if;
   logic        dm_req = 1'b0;
   logic [3:0]  dm_wen = '0;
   logic [31:0] dm_addr = '0;
   logic [31:0] dm_wdata = '0;
   logic [31:0] dm_rdata;
   logic        dm_rvalid;
   logic        stallreq_dm;
   logic        sram_en;
   logic [3:0]  sram_wen;
   logic [31:0] sram_addr;
   logic [31:0] sram_wdata;
   logic [31:0] sram_rdata;
`ifdef ARB_PERF_CNT_EN
   logic [31:0] perf_conflict_cnt;
   logic [31:0] perf_force_cnt;
`endif

   mem_port_arbiter #(.RD_LATENCY(L), .STREAK_MAX(SMAX)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_rvalid(if_rvalid),
      .stallreq_if(stallreq_if),
      .dm_req(dm_req), .dm_wen(dm_wen), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_rvalid(dm_rvalid), .stallreq_dm(stallreq_dm),
      .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
      .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
`ifdef ARB_PERF_CNT_EN
      , .perf_conflict_cnt(perf_conflict_cnt), .perf_force_cnt(perf_force_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        en;
      logic [3:0]  wen;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        st_if;
      logic        st_dm;
      logic [31:0] pc;
      logic [31:0] pf;
   } bus_t;

   typedef struct {
      int          due;
      logic [31:0] data;
   } rsp_t;

   bus_t        gq[$];
   rsp_t        if_q[$];
   rsp_t        dm_q[$];
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   bit          started = 0;
   logic [31:0] last_if = '0;
   logic [31:0] last_dm = '0;
   logic [31:0] ref_mem [16];
   logic [31:0] sram_mem [16];
   logic [31:0] rd_pipe [L];
   int          if_wait = 0;
   bit          if_pend = 0;
   bit          dm_pend = 0;
   logic [31:0] pc_cnt = '0;
   logic [31:0] pf_cnt = '0;

   function automatic logic [31:0] init_word(input int i);
      return (32'h9E3779B9 * 32'(i + 1)) ^ 32'h5A5A0000;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Behavioural SRAM: read data appears L cycles after the enable; other cycles return noise.
   assign sram_rdata = rd_pipe[L-1];
   always @(posedge clk) begin
      if (cyc == 0) begin
         for (int i = 0; i < 16; i++) sram_mem[i] <= init_word(i);
      end else if (sram_en && sram_wen != 4'h0) begin
         for (int b = 0; b < 4; b++)
            if (sram_wen[b]) sram_mem[sram_addr[5:2]][b*8 +: 8] <= sram_wdata[b*8 +: 8];
      end
      rd_pipe[0] <= (sram_en && sram_wen == 4'h0) ? sram_mem[sram_addr[5:2]] : $urandom;
      for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
   end

   // Reference model: DM wins unless IF has already lost SMAX times in a row while waiting.
   task automatic step(input bit rst_v, input int p_if, input int p_dm, input int p_wr, input int p_fl);
      bus_t e;
      bit   frc, g_if, g_dm;
      @(posedge clk);
      #1;
      cyc++;
      rst = rst_v;
      if (!if_pend) begin
         if_req  = ($urandom_range(99) < p_if);
         if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!dm_pend) begin
         dm_req   = ($urandom_range(99) < p_dm);
         dm_wen   = ($urandom_range(99) < p_wr) ? 4'($urandom_range(15, 1)) : 4'h0;
         dm_addr  = $urandom & 32'hFFFF_FFFC;
         dm_wdata = $urandom;
      end
      flush = ($urandom_range(99) < p_fl);
      e = '{en: 1'b0, wen: 4'h0, addr: '0, wdata: '0, st_if: 1'b0, st_dm: 1'b0, pc: '0, pf: '0};
      if (!rst_v) begin
         if_q.delete();
         dm_q.delete();
         if_wait = 0;
         if_pend = 0;
         dm_pend = 0;
         last_if = '0;
         last_dm = '0;
         pc_cnt  = '0;
         pf_cnt  = '0;
      end else begin
         e.pc = pc_cnt;
         e.pf = pf_cnt;
         frc  = (if_wait == SMAX);
         g_if = if_req && (!dm_req || frc);
         g_dm = dm_req && !g_if;
         e.st_if = if_req && !g_if;
         e.st_dm = dm_req && !g_dm;
         if (g_dm) begin
            e.en = 1'b1; e.wen = dm_wen; e.addr = dm_addr; e.wdata = dm_wdata;
         end else if (g_if) begin
            e.en = 1'b1; e.addr = if_addr;
         end
         if (if_req && dm_req) pc_cnt++;
         if (frc) pf_cnt++;
         if (flush) if_q.delete();
         if (g_if && !flush) if_q.push_back('{due: cyc + L, data: ref_mem[if_addr[5:2]]});
         if (g_dm && dm_wen == 4'h0) dm_q.push_back('{due: cyc + L, data: ref_mem[dm_addr[5:2]]});
         if (g_dm && dm_wen != 4'h0)
            for (int b = 0; b < 4; b++)
               if (dm_wen[b]) ref_mem[dm_addr[5:2]][b*8 +: 8] = dm_wdata[b*8 +: 8];
         if (!if_req || g_if) if_wait = 0;
         else if (g_dm && if_wait < SMAX) if_wait++;
         if_pend = if_req && !g_if;
         dm_pend = dm_req && !g_dm;
      end
      gq.push_back(e);
      started = 1;
   endtask

   // Monitor: compares the bus each cycle and pops response expectations as they fall due.
   always @(negedge clk) begin
      bus_t e;
      rsp_t r;
      bit   exp_v;
      if (started) begin
         if (gq.size() == 0) begin
            chk("grant_queue", 32'(gq.size()), 32'd1);
         end else begin
            e = gq.pop_front();
            chk("sram_en", sram_en, e.en);
            chk("sram_wen", sram_wen, e.wen);
            chk("sram_addr", sram_addr, e.addr);
            chk("sram_wdata", sram_wdata, e.wdata);
            chk("stallreq_if", stallreq_if, e.st_if);
            chk("stallreq_dm", stallreq_dm, e.st_dm);
`ifdef ARB_PERF_CNT_EN
            chk("perf_conflict", perf_conflict_cnt, e.pc);
            chk("perf_force", perf_force_cnt, e.pf);
`endif
         end
         exp_v = (if_q.size() > 0) && (if_q[0].due == cyc);
         chk("if_rvalid", if_rvalid, exp_v);
         if (exp_v) begin
            r = if_q.pop_front();
            if (if_rvalid) begin
               chk("if_rdata", if_rdata, r.data);
               last_if = r.data;
            end
         end else if (!if_rvalid) begin
            chk("if_rdata_hold", if_rdata, last_if);
         end
         exp_v = (dm_q.size() > 0) && (dm_q[0].due == cyc);
         chk("dm_rvalid", dm_rvalid, exp_v);
         if (exp_v) begin
            r = dm_q.pop_front();
            if (dm_rvalid) begin
               chk("dm_rdata", dm_rdata, r.data);
               last_dm = r.data;
            end
         end else if (!dm_rvalid) begin
            chk("dm_rdata_hold", dm_rdata, last_dm);
         end
      end
   end

   initial begin
      for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
      for (int i = 0; i < L; i++) rd_pipe[i] = '0;
      repeat (3) step(0, 50, 50, 30, 0);
      repeat (20) step(1, 70, 0, 0, 0);
      repeat (30) step(1, 100, 100, 30, 0);
      repeat (600) step(1, 60, 60, 40, 8);
      repeat (4) step(1, 0, 0, 0, 0);
      step(1, 100, 0, 0, 0);
      repeat (2) step(0, 100, 100, 0, 0);
      repeat (8) step(1, 0, 0, 0, 0);
      repeat (200) step(1, 80, 80, 30, 5);
      repeat (10) step(1, 0, 0, 0, 0);
      @(negedge clk);
      #1;
      chk("if_q_drained", 32'(if_q.size()), 32'd0);
      chk("dm_q_drained", 32'(dm_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished (cycle %0d)", cyc);
      $fatal(1);
   end
endmodule
